// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream loader that fills instruction memory and releases CPU reset
//
// Accepts a frame of SYNC_BYTE, LEN_LO, LEN_HI, 4*N data bytes and CHK.
// Data bytes are packed little-endian into 32-bit words and written to
// instruction memory one word at a time.
// CHK is the XOR of the data bytes only.
// The CPU is held in reset until a frame with a good checksum has loaded.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   in_valid      byte stream valid
//   in_data       byte stream data
//   in_ready      loader can accept a byte (low during rst, DONE and ERROR)
//   imem_we       one-cycle instruction memory write strobe
//   imem_addr     word index being written
//   imem_wdata    instruction word {b3,b2,b1,b0}
//   cpu_rst       reset to the CPU, high until a load succeeds
//   done          frame loaded with a good checksum (sticky until rst)
//   error         frame rejected (sticky until rst)
//   words_loaded  count of words written so far

module imem_boot_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  // Largest word count that fits in memory; the extra bit lets 2**ADDR_W
  // itself be represented for the compare against a 16-bit length.
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  logic [2:0]  state;
  logic [7:0]  len_lo;
  logic [15:0] len_words;
  logic [1:0]  byte_cnt;
  logic [23:0] shift_buf;
  logic [7:0]  xor_acc;

  logic        accept;
  logic [15:0] frame_len;
  logic [15:0] next_count;

  // Both terminal states refuse input; rst forces in_ready low while asserted.
  assign in_ready = !rst && (state != S_DONE) && (state != S_ERROR);
  assign accept   = in_valid && in_ready;

  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);
  assign cpu_rst  = (state != S_DONE);

  // Length as it will be once LEN_HI is latched this cycle.
  assign frame_len  = {in_data, len_lo};
  // Word count after the word currently completing; equals len_words on the
  // last word of the frame.
  assign next_count = 16'(words_loaded) + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len_lo       <= 8'h00;
      len_words    <= 16'h0000;
      byte_cnt     <= 2'd0;
      shift_buf    <= 24'h000000;
      xor_acc      <= 8'h00;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'h00000000;
      words_loaded <= '0;
    end else begin
      // The write strobe is a single-cycle pulse; address and data hold.
      imem_we <= 1'b0;

      if (accept) begin
        case (state)
          S_IDLE: begin
            // Anything other than the marker is silently dropped.
            if (in_data == SYNC_BYTE) begin
              state <= S_LEN0;
            end
          end

          S_LEN0: begin
            len_lo <= in_data;
            state  <= S_LEN1;
          end

          S_LEN1: begin
            len_words <= frame_len;
            if ({1'b0, frame_len} > MAX_WORDS) begin
              state <= S_ERROR;
            end else if (frame_len == 16'h0000) begin
              state <= S_CHECK;
            end else begin
              state <= S_DATA;
            end
          end

          S_DATA: begin
            xor_acc  <= xor_acc ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // words_loaded doubles as the index of the word being written,
              // so the address is its value before the increment.
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= {in_data, shift_buf};
              words_loaded <= words_loaded + 1'b1;
              if (next_count == len_words) begin
                state <= S_CHECK;
              end
            end else begin
              // Oldest byte ends up in the low lane: {b2,b1,b0} after three.
              shift_buf <= {in_data, shift_buf[23:8]};
            end
          end

          S_CHECK: begin
            if (in_data == xor_acc) begin
              state <= S_DONE;
            end else begin
              state <= S_ERROR;
            end
          end

          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader

module tb_imem_boot_loader;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int tests;
  int fails;
  int wr_count;
  int wr_base;

  imem_boot_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      check("ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_flags", {30'd0, done, error}, 32'd0);
    check("rst_we_words", {22'd0, imem_we, words_loaded}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle_writes();
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    wr_count = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_addr", {24'd0, imem_addr}, 32'd0);
    check("reset_wdata", imem_wdata, 32'd0);
    do_reset();
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Nominal two-word load; XOR of the eight data bytes is 0xC2
    settle_writes();
    wr_base = wr_count;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h10);
    check("nom_no_early_we", {31'd0, imem_we}, 32'd0);
    send_byte(8'h00);
    check("nom_we0", {31'd0, imem_we}, 32'd1);
    check("nom_addr0", {24'd0, imem_addr}, 32'd0);
    check("nom_data0", imem_wdata, 32'h00100013);
    check("nom_words1", {23'd0, words_loaded}, 32'd1);
    send_byte(8'hB7); send_byte(8'h50); send_byte(8'h34);
    check("nom_we_pulse", {31'd0, imem_we}, 32'd0);
    send_byte(8'h12);
    check("nom_we1", {31'd0, imem_we}, 32'd1);
    check("nom_addr1", {24'd0, imem_addr}, 32'd1);
    check("nom_data1", imem_wdata, 32'h123450B7);
    check("nom_pre_chk", {29'd0, cpu_rst, done, error}, 32'b100);
    send_byte(8'hC2);
    check("nom_done", {29'd0, done, error, cpu_rst}, 32'b100);
    check("nom_in_ready", {31'd0, in_ready}, 32'd0);
    check("nom_words2", {23'd0, words_loaded}, 32'd2);
    settle_writes();
    check("nom_wr_count", wr_count - wr_base, 32'd2);

    // Same frame with a wrong checksum
    do_reset();
    settle_writes();
    wr_base = wr_count;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'hB7); send_byte(8'h50); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h49);
    check("bad_chk_flags", {29'd0, done, error, cpu_rst}, 32'b011);
    check("bad_chk_in_ready", {31'd0, in_ready}, 32'd0);
    settle_writes();
    check("bad_chk_writes", wr_count - wr_base, 32'd2);
    check("bad_chk_words", {23'd0, words_loaded}, 32'd2);

    // Garbage before sync, then one word 0x12345678 with CHK 0x08
    do_reset();
    settle_writes();
    wr_base = wr_count;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("garb_idle", {28'd0, in_ready, imem_we, done, error}, 32'b1000);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("garb_addr", {24'd0, imem_addr}, 32'd0);
    check("garb_data", imem_wdata, 32'h12345678);
    send_byte(8'h08);
    check("garb_done", {30'd0, done, error}, 32'b10);
    settle_writes();
    check("garb_writes", wr_count - wr_base, 32'd1);

    // Oversize length 257
    do_reset();
    settle_writes();
    wr_base = wr_count;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    check("over_flags", {28'd0, in_ready, done, error, cpu_rst}, 32'b0011);
    settle_writes();
    check("over_writes", wr_count - wr_base, 32'd0);

    // Length exactly 256 is accepted
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    check("max_len_ok", {29'd0, in_ready, done, error}, 32'b100);

    // Zero length frame
    do_reset();
    settle_writes();
    wr_base = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("zero_done", {29'd0, done, error, cpu_rst}, 32'b100);
    settle_writes();
    check("zero_writes", wr_count - wr_base, 32'd0);
    check("zero_words", {23'd0, words_loaded}, 32'd0);

    // Stalled one-word frame 0xDEADBEEF, CHK 0x22
    do_reset();
    settle_writes();
    wr_base = wr_count;
    send_byte(8'hA5); repeat (3) @(negedge clk);
    send_byte(8'h01); repeat (3) @(negedge clk);
    send_byte(8'h00); repeat (3) @(negedge clk);
    send_byte(8'hEF); repeat (3) @(negedge clk);
    send_byte(8'hBE); repeat (3) @(negedge clk);
    check("stall_no_we", {31'd0, imem_we}, 32'd0);
    send_byte(8'hAD); repeat (3) @(negedge clk);
    send_byte(8'hDE);
    check("stall_we", {31'd0, imem_we}, 32'd1);
    check("stall_data", imem_wdata, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    send_byte(8'h22);
    check("stall_done", {30'd0, done, error}, 32'b10);
    settle_writes();
    check("stall_writes", wr_count - wr_base, 32'd1);

    // Reset after two data bytes, then fresh frame 0xCAFEBABE, CHK 0x30
    do_reset();
    settle_writes();
    wr_base = wr_count;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    do_reset();
    check("mid_rst_addr", {24'd0, imem_addr}, 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hBE); send_byte(8'hBA); send_byte(8'hFE); send_byte(8'hCA);
    check("mid_rst_addr0", {24'd0, imem_addr}, 32'd0);
    check("mid_rst_data", imem_wdata, 32'hCAFEBABE);
    send_byte(8'h30);
    check("mid_rst_done", {29'd0, done, error, cpu_rst}, 32'b100);
    settle_writes();
    check("mid_rst_writes", wr_count - wr_base, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
